// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serialises a word-wide bitstream onto the head of a
// ccff scan chain and can rotate the chain once afterwards to check load parity.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 32,
  localparam int CNT_W    = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              chain_en,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int WR_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    VERIFY,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sreg;
  logic [WR_W-1:0]   word_remain;
  logic [CNT_W-1:0]  vcount;
  logic              load_par, tail_par, verify_lat, error_q;
  logic              last_bit, last_verify;

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    word_ready  = 1'b0;
    chain_en    = 1'b0;
    ccff_head   = 1'b0;
    busy        = 1'b0;
    last_bit    = (bit_count == CNT_W'(CHAIN_LEN - 1));
    last_verify = (vcount == CNT_W'(CHAIN_LEN - 1));
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        word_ready = 1'b1;
        busy       = 1'b1;
        if (word_valid) state_d = SHIFT;
      end
      SHIFT: begin
        chain_en  = 1'b1;
        ccff_head = sreg[0];
        busy      = 1'b1;
        // The chain length wins over the word boundary, so surplus word bits are dropped.
        if (last_bit)                        state_d = verify_lat ? VERIFY : DONE;
        else if (word_remain == WR_W'(1))    state_d = FETCH;
      end
      VERIFY: begin
        chain_en  = 1'b1;
        ccff_head = ccff_tail;
        busy      = 1'b1;
        if (last_verify) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      sreg        <= '0;
      word_remain <= '0;
      bit_count   <= '0;
      vcount      <= '0;
      load_par    <= 1'b0;
      tail_par    <= 1'b0;
      verify_lat  <= 1'b0;
      error_q     <= 1'b0;
    end else if (abort) begin
      error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            bit_count  <= '0;
            vcount     <= '0;
            load_par   <= 1'b0;
            tail_par   <= 1'b0;
            error_q    <= 1'b0;
            verify_lat <= verify_en;
          end
        end
        FETCH: begin
          if (word_valid) begin
            sreg        <= word_data;
            word_remain <= WR_W'(WORD_W);
          end
        end
        SHIFT: begin
          sreg        <= sreg >> 1;
          bit_count   <= bit_count + CNT_W'(1);
          load_par    <= load_par ^ sreg[0];
          word_remain <= word_remain - WR_W'(1);
        end
        VERIFY: begin
          // Every loaded bit leaves the tail exactly once during the rotation.
          tail_par <= tail_par ^ ccff_tail;
          vcount   <= vcount + CNT_W'(1);
          if (last_verify) error_q <= ((tail_par ^ ccff_tail) != load_par);
        end
        default: ;
      endcase
    end
  end

  assign done  = (state_q == DONE);
  assign error = error_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomised bench for ccff_chain_loader: a 10-stage behavioural chain plus a
// bitstream-level reference model, and a 1-stage instance for the minimal case.
module tb_ccff_chain_loader;

  localparam int CL = 10;
  localparam int WW = 4;
  localparam int CW = $clog2(CL + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0, verify_en = 1'b0, word_valid = 1'b0;
  logic [WW-1:0] word_data = '0;
  logic          word_ready, chain_en, ccff_head, ccff_tail, busy, done, error;
  logic [CW-1:0] bit_count;
  logic [CL-1:0] chain = '0;
  logic          tail_flip = 1'b0;

  logic          s_start = 1'b0, s_abort = 1'b0, s_verify_en = 1'b0, s_word_valid = 1'b0;
  logic [0:0]    s_word_data = '0;
  logic          s_word_ready, s_chain_en, s_head, s_busy, s_done, s_error;
  logic [0:0]    s_bit_count;
  logic          s_chain = 1'b0;

  int            checks = 0;
  int            errors = 0;
  logic [WW-1:0] words [3];
  logic [CL-1:0] last_stream;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk(clk), .prog_reset(rst), .start(start), .abort(abort),
    .verify_en(verify_en), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .chain_en(chain_en), .ccff_head(ccff_head),
    .ccff_tail(ccff_tail), .busy(busy), .done(done), .error(error),
    .bit_count(bit_count)
  );

  ccff_chain_loader #(.CHAIN_LEN(1), .WORD_W(1)) dut_small (
    .prog_clk(clk), .prog_reset(rst), .start(s_start), .abort(s_abort),
    .verify_en(s_verify_en), .word_data(s_word_data), .word_valid(s_word_valid),
    .word_ready(s_word_ready), .chain_en(s_chain_en), .ccff_head(s_head),
    .ccff_tail(s_chain), .busy(s_busy), .done(s_done), .error(s_error),
    .bit_count(s_bit_count)
  );

  always #5 clk = ~clk;

  // Physical chains: stage 0 takes ccff_head, the last stage drives ccff_tail.
  assign ccff_tail = chain[CL-1] ^ tail_flip;
  always @(posedge clk) if (chain_en) chain <= {chain[CL-2:0], ccff_head};
  always @(posedge clk) if (s_chain_en) s_chain <= s_head;

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bitstream order: word 0 bit 0 first, truncated at CHAIN_LEN bits.
  function automatic logic [CL-1:0] stream_of();
    logic [CL-1:0] s;
    for (int i = 0; i < CL; i++) s[i] = words[i / WW][i % WW];
    return s;
  endfunction

  task automatic randomize_words();
    for (int i = 0; i < 3; i++) words[i] = WW'($urandom);
  endtask

  task automatic applyStimulus(input logic ver, input logic flip, input int stall_pct,
                               input int hold_n, output logic [CL-1:0] head_stream,
                               output int en_cycles, output int ready_cycles,
                               output int transfers, output int verify_bad);
    int widx, held, vcyc, nbits;
    widx = 0; held = 0; vcyc = 0; nbits = 0;
    head_stream = '0; en_cycles = 0; ready_cycles = 0; transfers = 0; verify_bad = 0;
    @(negedge clk);
    verify_en = ver;
    start     = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      start     = 1'b0;
      verify_en = 1'b0;
      tail_flip = 1'b0;
      if (done) break;
      if (flip && chain_en && nbits >= CL && vcyc == 3) tail_flip = 1'b1;
      if (word_ready) begin
        if (widx == 1 && held < hold_n) begin
          word_valid = 1'b0;
          held++;
        end else begin
          word_valid = (widx < 3) && ($urandom_range(99) >= stall_pct);
        end
        word_data = (widx < 3) ? words[widx] : WW'($urandom);
      end else begin
        word_valid = 1'($urandom_range(1));
        word_data  = WW'($urandom);
      end
      #1;
      if (word_ready) begin
        ready_cycles++;
        if (word_valid) begin
          transfers++;
          widx++;
        end
      end
      if (chain_en) begin
        en_cycles++;
        if (nbits < CL) head_stream[nbits] = ccff_head;
        else begin
          if (ccff_head !== ccff_tail) verify_bad++;
          vcyc++;
        end
        nbits++;
      end
    end
    word_valid = 1'b0;
  endtask

  task automatic check_load(input logic ver, input logic flip, input int stall_pct, input int hold_n);
    logic [CL-1:0] exp_s, exp_c, got_s;
    int en, rc, tr, vb, stray;
    exp_s = stream_of();
    for (int i = 0; i < CL; i++) exp_c[CL-1-i] = exp_s[i];
    applyStimulus(ver, flip, stall_pct, hold_n, got_s, en, rc, tr, vb);
    last_stream = got_s;
    checkOutput("done", done, 1);
    checkOutput("head_stream", got_s, exp_s);
    checkOutput("chain_en_cycles", en, ver ? 2 * CL : CL);
    checkOutput("transfers", tr, 3);
    checkOutput("bit_count", bit_count, CL);
    checkOutput("error", error, flip);
    checkOutput("busy_in_done", busy, 0);
    if (ver) checkOutput("verify_head_is_tail", vb, 0);
    if (!flip) checkOutput("chain_contents", chain, exp_c);
    if (hold_n == 0 && stall_pct == 0) checkOutput("fetch_cycles", rc, 3);
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (word_ready || chain_en) stray++;
    end
    checkOutput("quiet_after_done", stray, 0);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_word_ready"}, word_ready, 0);
    checkOutput({tag, "_chain_en"}, chain_en, 0);
    checkOutput({tag, "_ccff_head"}, ccff_head, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_error"}, error, 0);
    checkOutput({tag, "_bit_count"}, bit_count, 0);
  endtask

  initial begin
    int   widx;
    logic hit;
    logic got_bit;
    int   en;

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    words[0] = 4'h5; words[1] = 4'hA; words[2] = 4'h3;
    check_load(1'b0, 1'b0, 0, 0);
    checkOutput("basic_stream_literal", last_stream, 32'b1110100101);
    check_load(1'b0, 1'b0, 0, 5);
    check_load(1'b1, 1'b0, 0, 0);
    check_load(1'b1, 1'b1, 0, 0);
    checkOutput("mismatch_done", done, 1);

    repeat (6) begin
      randomize_words();
      check_load(1'($urandom_range(1)), 1'b0, 30, 0);
    end

    // Abort once six bits have gone into the chain.
    randomize_words();
    widx = 0; hit = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (bit_count == CW'(6) && busy) begin
        abort = 1'b1;
        hit   = 1'b1;
      end
      word_valid = 1'b1;
      word_data  = (widx < 3) ? words[widx] : WW'(0);
      if (word_ready && !hit) widx++;
    end
    checkOutput("abort_reached", hit, 1);
    @(negedge clk);
    abort = 1'b0;
    word_valid = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_chain_en", chain_en, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_word_ready", word_ready, 0);
    checkOutput("abort_error", error, 0);
    checkOutput("abort_bit_count", bit_count, 6);
    randomize_words();
    check_load(1'b0, 1'b0, 0, 0);

    // Asynchronous reset in the middle of SHIFT.
    randomize_words();
    widx = 0; hit = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (bit_count == CW'(3) && chain_en) hit = 1'b1;
      word_valid = 1'b1;
      word_data  = (widx < 3) ? words[widx] : WW'(0);
      if (word_ready) widx++;
    end
    checkOutput("reset_mid_reached", hit, 1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    word_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    randomize_words();
    check_load(1'b1, 1'b0, 20, 0);

    // Single-stage chain with one-bit words.
    for (int t = 0; t < 2; t++) begin
      got_bit = 1'bx;
      en = 0;
      @(negedge clk);
      s_start      = 1'b1;
      s_word_data  = 1'(t);
      s_word_valid = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
        @(negedge clk);
        s_start = 1'b0;
        if (s_done) break;
        #1;
        if (s_chain_en) begin
          en++;
          got_bit = s_head;
        end
      end
      s_word_valid = 1'b0;
      checkOutput("small_done", s_done, 1);
      checkOutput("small_shift_cycles", en, 1);
      checkOutput("small_head", got_bit, t);
      checkOutput("small_bit_count", s_bit_count, 1);
      checkOutput("small_chain", s_chain, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Configuration-chain controller that drives the head of a ccff scan chain built from configuration-memory DFF stages (mux_tree_tapbuf_*_mem instances and similar).
- Accepts the bitstream as WORD_W-bit words over a valid/ready interface and serialises exactly CHAIN_LEN bits onto ccff_head.
- Qualifies each chain shift with chain_en, the clock-gate enable for the chain's prog_clk.
- Optional verify pass rotates the chain once (tail fed back to head), checks parity of the loaded data, and leaves the chain contents unchanged.

Parameters:
- CHAIN_LEN, 1024: number of DFF stages in the target chain (bits to load); must be >= 1.
- WORD_W, 32: bitstream word width; must be >= 1.
- CNT_W, $clog2(CHAIN_LEN+1): width of bit counters (derived; do not override).

Ports:
- prog_clk  in  1  programming clock; all state updates on its rising edge.
- prog_reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load; honoured only in IDLE or DONE.
- abort  in  1  when high, forces IDLE on the next edge from any state.
- verify_en  in  1  sampled with start; 1 = run the verify pass after loading.
- word_data  in  WORD_W  bitstream word; bit 0 is shifted first.
- word_valid  in  1  word_data valid.
- word_ready  out  1  high only in FETCH; transfer occurs on word_valid && word_ready.
- chain_en  out  1  chain shift enable (clock-gate enable); the chain shifts one stage on each prog_clk edge where it is 1.
- ccff_head  out  1  serial data into the chain.
- ccff_tail  in  1  serial data from the chain's last stage.
- busy  out  1  high in FETCH, SHIFT and VERIFY.
- done  out  1  level; high in DONE; cleared by start or abort.
- error  out  1  level; verify parity mismatch; cleared by start, abort or reset.
- bit_count  out  CNT_W  bits shifted into the chain so far in the current load.

Behaviour:
- Reset: state = IDLE; all outputs 0 (word_ready, chain_en, ccff_head, busy, done, error, bit_count); shift register and parity registers cleared.
- States: IDLE, FETCH, SHIFT, VERIFY, DONE.
- IDLE/DONE + start: go to FETCH.
  - Clear bit_count, done, error and load parity.
  - Latch verify_en.
  - If start and abort are both high, abort wins.
- FETCH:
  - word_ready = 1 and chain_en = 0.
  - On transfer: load the shift register with word_data, set word_remain = WORD_W, go to SHIFT.
  - If word_valid is low, stay in FETCH indefinitely.
- SHIFT, each cycle:
  - chain_en = 1; ccff_head = sreg[0].
  - sreg shifts right; bit_count += 1; load parity ^= sreg[0]; word_remain -= 1.
  - Leave on the cycle the shifted bit is the last:
    - If bit_count reaches CHAIN_LEN: go to VERIFY if the latched verify_en is 1, else go to DONE.
    - Else if word_remain reaches 0: go to FETCH.
  - CHAIN_LEN has priority: unused high bits of the final word are discarded, and no further word is requested.
- Throughput: each word costs 1 FETCH cycle plus its shift cycles (one bubble per word, chain_en = 0 during the bubble).
- VERIFY, exactly CHAIN_LEN cycles:
  - chain_en = 1; ccff_head = ccff_tail (combinational, no loop because ccff_tail is a DFF output).
  - tail parity ^= ccff_tail each cycle.
  - After the last cycle: go to DONE, with error = (tail parity != load parity).
  - After the pass the chain holds exactly what it held at the end of SHIFT.
- DONE: done = 1, busy = 0; error holds its value. start re-enters FETCH.
- Default value of ccff_head is 0 whenever chain_en = 0.
- abort: on the next edge, state = IDLE and chain_en, word_ready, done, error = 0. A word offered in the same cycle is not transferred. Partially loaded chain contents are left as-is. bit_count holds its value for debug.
- start while busy is ignored.
- Asynchronous prog_reset mid-load returns to the reset state immediately, with chain_en = 0 in the same cycle.

Test Plan (CHAIN_LEN=10, WORD_W=4 unless stated):
- Basic load, verify_en=0, words 0x5, 0xA, 0x3 with valid always high:
  - ccff_head sequence is 1,0,1,0,0,1,0,1,1,1.
  - chain_en is high for exactly 10 cycles with 2 FETCH bubbles.
  - The 3rd word's bits 2–3 are discarded.
  - done rises; bit_count = 10; word_ready is never high again.
- Backpressure: word_valid low for 5 cycles before the 2nd word -> FETCH holds, chain_en stays 0 throughout, final chain contents are identical to the basic load.
- Verify pass with a behavioural 10-stage chain model, verify_en=1, same words -> 10 extra chain_en cycles with ccff_head equal to ccff_tail; error = 0; chain contents unchanged afterwards.
- Verify mismatch: force one chain stage to flip during VERIFY -> error = 1 and done = 1 at the end.
- Abort after 6 bits shifted -> next cycle state = IDLE, chain_en = 0, done = 0, bit_count = 6; a new start reloads from bit 0.
- Reset mid-SHIFT (prog_reset asserted between edges) -> all outputs 0 immediately. Also: CHAIN_LEN=1, WORD_W=1 single-bit load completes in 1 shift cycle with done = 1.
